// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU, one op per valid/ready handshake, result plus carry/zero/parity flags
// Ports: clk; reset_n (sync, active-low); in_valid/in_ready with alu_cmd, inA, inB, sc_i accept an op;
//        out_valid/out_ready return rslt, sc_o, zero, pari, illegal. Define ALU_MUL_EN to build the multiplier.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         sc_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] rslt,
  output logic         sc_o,
  output logic         zero,
  output logic         pari,
  output logic         illegal
);
  localparam int SH_W = $clog2(W);
  localparam int CW = $clog2(W + 1);
  localparam logic [2:0] ADD = 3'd0, SHL1 = 3'd1, SHR1 = 3'd2, NAND = 3'd3;
  localparam logic [2:0] SUB = 3'd4, SHLN = 3'd5, MUL = 3'd6, XOR = 3'd7;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t st;
  logic [W-1:0] a;
  logic [CW-1:0] cnt;
  logic [SH_W-1:0] n;
  logic [W:0] add_s, sub_s, s_cr, e_cr, f_cr;
  logic s_ill, iter, f_go, f_ill;
  assign n = inB[SH_W-1:0];
  assign in_ready = st == IDLE;
  assign add_s = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, sc_i};
  assign sub_s = {1'b0, inA} + {1'b0, ~inB} + {{W{1'b0}}, sc_i};
`ifdef ALU_MUL_EN
  logic mul_r;
  logic [W-1:0] b;
  logic [2*W-1:0] mc, acc, acc_n;
  assign acc_n = acc + (b[0] ? mc : '0);
  assign iter = (alu_cmd == SHLN && n != '0) || alu_cmd == MUL;
  assign s_ill = 1'b0;
  assign e_cr = mul_r ? {|acc_n[2*W-1:W], acc_n[W-1:0]} : {a, 1'b0};
  always_ff @(posedge clk)
    if (in_ready) begin
      mul_r <= alu_cmd == MUL;
      b <= inB;
      mc <= {{W{1'b0}}, inA};
      acc <= '0;
    end else if (st == EXEC) begin
      b <= b >> 1;
      mc <= mc << 1;
      acc <= acc_n;
    end
`else
  assign iter = alu_cmd == SHLN && n != '0;
  assign s_ill = alu_cmd == MUL;
  assign e_cr = {a, 1'b0};
`endif
  // {carry, result} for every op that completes in the accept cycle
  always_comb begin
    s_cr = '0;
    case (alu_cmd)
      ADD:     s_cr = add_s;
      SHL1:    s_cr = {inA, sc_i};
      SHR1:    s_cr = {inA[0], sc_i, inA[W-1:1]};
      NAND:    s_cr = {1'b0, ~(inA & inB)};
      SUB:     s_cr = sub_s;
      SHLN:    s_cr = {1'b0, inA};
      XOR:     s_cr = {1'b0, inA ^ inB};
      default: s_cr = '0;
    endcase
  end
  // the last EXEC cycle writes its next-state value straight into the result registers
  assign f_go = (in_ready && in_valid && !iter) || (st == EXEC && cnt == CW'(1));
  assign f_cr = st == EXEC ? e_cr : s_cr;
  assign f_ill = st == EXEC ? 1'b0 : s_ill;
  always_ff @(posedge clk)
    if (in_ready) begin
      a <= inA;
      cnt <= alu_cmd == MUL ? CW'(W) : CW'(n);
    end else if (st == EXEC) begin
      a <= a << 1;
      cnt <= cnt - CW'(1);
    end
  always_ff @(posedge clk)
    if (!reset_n) begin
      st <= IDLE;
      out_valid <= 1'b0;
      rslt <= '0;
      sc_o <= 1'b0;
      zero <= 1'b1;
      pari <= 1'b0;
      illegal <= 1'b0;
    end else if (f_go) begin
      st <= DONE;
      out_valid <= 1'b1;
      {sc_o, rslt} <= f_cr;
      zero <= ~|f_cr[W-1:0];
      pari <= ^f_cr[W-1:0];
      illegal <= f_ill;
    end else if (in_ready && in_valid) st <= EXEC;
    else if (st == DONE && out_ready) begin
      st <= IDLE;
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;
  localparam int W = 8;
  localparam longint MASK = (64'd1 << W) - 1;
  typedef struct packed {
    logic [2:0] cmd;
    logic [W-1:0] a, b;
    logic ci;
    logic [3:0] lat;
    logic [W+3:0] ex;
  } vec_t;
  logic clk = 0, reset_n = 0, in_valid = 0, out_ready = 0, sc_i = 0;
  logic [2:0] alu_cmd = 0;
  logic [W-1:0] inA = 0, inB = 0;
  logic in_ready, out_valid, sc_o, zero, pari, illegal;
  logic [W-1:0] rslt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  alu_seq #(.W(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .sc_i(sc_i),
    .out_valid(out_valid), .out_ready(out_ready), .rslt(rslt), .sc_o(sc_o),
    .zero(zero), .pari(pari), .illegal(illegal)
  );
  function automatic void model(input logic [2:0] cmd, input logic [W-1:0] a, b, input logic ci,
                                output logic [W-1:0] r, output logic c, output logic ill, output int lat);
    longint la = longint'(a), lb = longint'(b), v = 0;
    int n = int'(b) % W;
    ill = 0; lat = 1; c = 0; r = 0;
    case (cmd)
      3'd0: begin v = la + lb + longint'(ci); r = v[W-1:0]; c = v[W]; end
      3'd1: begin v = la * 2 + longint'(ci); r = v[W-1:0]; c = v[W]; end
      3'd2: begin v = (longint'(ci) << (W - 1)) + la / 2; r = v[W-1:0]; c = a[0]; end
      3'd3: r = ~(a & b);
      3'd4: begin v = la + ((~lb) & MASK) + longint'(ci); r = v[W-1:0]; c = v[W]; end
      3'd5: begin v = la << n; r = v[W-1:0]; c = v[W]; lat = n + 1; end
      3'd6: begin
`ifdef ALU_MUL_EN
        v = la * lb; r = v[W-1:0]; c = (v >> W) != 0; lat = W + 1;
`else
        ill = 1;
`endif
      end
      default: r = a ^ b;
    endcase
  endfunction
  function automatic logic [W+3:0] pack(input logic c, input logic [W-1:0] r, input logic ill);
    return {c, r, r == 0, ($countones(r) % 2) == 1, ill};
  endfunction
  task automatic run_op(input logic [2:0] cmd, input logic [W-1:0] a, b, input logic ci,
                        input logic hold, output int lat);
    alu_cmd = cmd; inA = a; inB = b; sc_i = ci; in_valid = 1; out_ready = 0;
    @(negedge clk);
    in_valid = hold; lat = 1;
    inA = W'($urandom); inB = W'($urandom); sc_i = 1'($urandom); alu_cmd = 3'($urandom);
    while (!out_valid && lat < 4 * W) begin
      @(negedge clk);
      lat++;
      inA = W'($urandom); inB = W'($urandom); alu_cmd = 3'($urandom);
    end
    in_valid = 0;
    if (!out_valid) lat = -1;
  endtask
  task automatic release_op;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask
  task automatic test_reset;
    reset_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rslt, sc_o, zero, pari, illegal, out_valid, in_ready} !== {8'h00, 6'b010001}) begin
      failures++;
      $display("FAIL reset_state got %h/%b want 00/010001", rslt, {sc_o, zero, pari, illegal, out_valid, in_ready});
    end
    reset_n = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask
  task automatic test_directed;
    vec_t tv [7];
    int lat;
    tv[0] = '{3'd0, 8'hFF, 8'h01, 1'b0, 4'd1, {1'b1, 8'h00, 3'b100}};
    tv[1] = '{3'd4, 8'h05, 8'h07, 1'b1, 4'd1, {1'b0, 8'hFE, 3'b010}};
    tv[2] = '{3'd2, 8'h81, 8'h00, 1'b1, 4'd1, {1'b1, 8'hC0, 3'b000}};
    tv[3] = '{3'd5, 8'hA1, 8'h03, 1'b0, 4'd4, {1'b1, 8'h08, 3'b010}};
    tv[4] = '{3'd5, 8'hA1, 8'h00, 1'b0, 4'd1, {1'b0, 8'hA1, 3'b010}};
`ifdef ALU_MUL_EN
    tv[5] = '{3'd6, 8'h0D, 8'h0B, 1'b0, 4'd9, {1'b0, 8'h8F, 3'b010}};
    tv[6] = '{3'd6, 8'h10, 8'h10, 1'b0, 4'd9, {1'b1, 8'h00, 3'b100}};
`else
    tv[5] = '{3'd6, 8'h0D, 8'h0B, 1'b0, 4'd1, {1'b0, 8'h00, 3'b101}};
    tv[6] = '{3'd6, 8'h10, 8'h10, 1'b0, 4'd1, {1'b0, 8'h00, 3'b101}};
`endif
    for (int i = 0; i < 7; i++) begin
      run_op(tv[i].cmd, tv[i].a, tv[i].b, tv[i].ci, 1'b0, lat);
      checks++;
      if (lat != int'(tv[i].lat)) begin
        failures++;
        $display("FAIL dir%0d_latency got %0d want %0d", i, lat, tv[i].lat);
      end
      checks++;
      if ({sc_o, rslt, zero, pari, illegal} !== tv[i].ex) begin
        failures++;
        $display("FAIL dir%0d_result got %h want %h", i, {sc_o, rslt, zero, pari, illegal}, tv[i].ex);
      end
      release_op;
    end
  endtask
  task automatic test_random;
    logic [2:0] cmd;
    logic [W-1:0] a, b, r;
    logic ci, c, ill;
    int lat, el;
    for (int i = 0; i < 80; i++) begin
      cmd = 3'($urandom); a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
      model(cmd, a, b, ci, r, c, ill, el);
      run_op(cmd, a, b, ci, 1'b0, lat);
      checks++;
      if (lat != el) begin
        failures++;
        $display("FAIL rnd%0d_latency cmd=%0d got %0d want %0d", i, cmd, lat, el);
      end
      checks++;
      if ({sc_o, rslt, zero, pari, illegal} !== pack(c, r, ill)) begin
        failures++;
        $display("FAIL rnd%0d_result cmd=%0d a=%h b=%h ci=%b got %h want %h", i, cmd, a, b, ci,
                 {sc_o, rslt, zero, pari, illegal}, pack(c, r, ill));
      end
      release_op;
    end
  endtask
  task automatic test_backpressure;
    logic [W-1:0] a, b, r;
    logic c, ill;
    int lat, el;
    a = W'($urandom); b = W'($urandom);
    model(3'd0, a, b, 1'b1, r, c, ill, el);
    run_op(3'd0, a, b, 1'b1, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; alu_cmd = 3'd7; inA = W'($urandom); inB = W'($urandom);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, sc_o, rslt, zero, pari, illegal} !== {2'b10, pack(c, r, ill)}) begin
        failures++;
        $display("FAIL hold%0d got %h want %h", i, {out_valid, in_ready, sc_o, rslt, zero, pari, illegal},
                 {2'b10, pack(c, r, ill)});
      end
    end
    in_valid = 0;
    release_op;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask
  task automatic test_back_to_back;
    logic [2:0] cmd;
    logic [W-1:0] a, b, r;
    logic ci, c, ill;
    int lat, el;
    for (int i = 0; i < 10; i++) begin
      cmd = 3'($urandom); a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
      model(cmd, a, b, ci, r, c, ill, el);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b%0d_in_ready got %b want 1", i, in_ready);
      end
      run_op(cmd, a, b, ci, 1'b1, lat);
      checks++;
      if (lat != el || {sc_o, rslt, zero, pari, illegal} !== pack(c, r, ill)) begin
        failures++;
        $display("FAIL b2b%0d cmd=%0d lat got %0d want %0d result got %h want %h", i, cmd, lat, el,
                 {sc_o, rslt, zero, pari, illegal}, pack(c, r, ill));
      end
      release_op;
    end
  endtask
  task automatic test_reset_abort;
    int lat;
    bit seen = 0;
    run_op(3'd7, 8'h5A, 8'h0F, 1'b0, 1'b0, lat);
    release_op;
`ifdef ALU_MUL_EN
    alu_cmd = 3'd6; inA = 8'h0D; inB = 8'h0B;
`else
    alu_cmd = 3'd5; inA = 8'hFF; inB = 8'h07;
`endif
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, rslt, zero} !== {2'b01, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL abort_state got %h want %h", {out_valid, in_ready, rslt, zero}, {2'b01, 8'h00, 1'b1});
    end
    reset_n = 1;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_no_result out_valid seen=1 want 0");
    end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_back_to_back;
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
